divider: RTL

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/divider.sv
// rtl/divider.sv - 32-bit signed/unsigned restoring divider, one quotient bit per clock
// Result packs {remainder, quotient}; ready_o pulses for one cycle per completed divide.

module divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } stateT;

  stateT       state;
  stateT       nextState;

  logic [5:0]  iterCnt;
  logic [31:0] dividend;   // shifts left each step; quotient bits fill in from the LSB
  logic [31:0] divisor;
  logic [31:0] partRem;
  logic        negQuot;
  logic        negRem;

  logic        startReq;
  logic        divByZero;
  logic [31:0] absDividend;
  logic [31:0] absDivisor;
  logic [32:0] trial;
  logic        fits;
  logic [31:0] quotFinal;
  logic [31:0] remFinal;

  logic        loadOps;
  logic        doStep;
  logic        doFinish;
  logic        doZero;
  logic        readyNext;

  assign startReq    = start_i && !annul_i;
  assign divByZero   = (opdata2_i == 32'd0);
  assign absDividend = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
  assign absDivisor  = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

  assign trial     = {partRem, dividend[31]};
  assign fits      = (trial >= {1'b0, divisor});
  // Magnitude 0x8000_0000 negates to itself, which gives the required wrap for MIN / -1.
  assign quotFinal = negQuot ? -dividend : dividend;
  assign remFinal  = negRem ? -partRem : partRem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FREE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      FREE: begin
        if (startReq) begin
          nextState = divByZero ? BYZERO : ON;
        end
      end
      BYZERO: begin
        nextState = annul_i ? FREE : END;
      end
      ON: begin
        if (annul_i) begin
          nextState = FREE;
        end else if (iterCnt == 6'd32) begin
          nextState = END;
        end
      end
      END: begin
        nextState = FREE;
      end
      default: begin
        nextState = FREE;
      end
    endcase
  end

  always_comb begin
    loadOps   = 1'b0;
    doStep    = 1'b0;
    doFinish  = 1'b0;
    doZero    = 1'b0;
    readyNext = 1'b0;
    case (state)
      FREE: begin
        loadOps = startReq;
      end
      BYZERO: begin
        doZero    = !annul_i;
        readyNext = !annul_i;
      end
      ON: begin
        if (!annul_i) begin
          if (iterCnt == 6'd32) begin
            doFinish  = 1'b1;
            readyNext = 1'b1;
          end else begin
            doStep = 1'b1;
          end
        end
      end
      default: begin
        readyNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iterCnt  <= 6'd0;
      dividend <= 32'd0;
      divisor  <= 32'd0;
      partRem  <= 32'd0;
      negQuot  <= 1'b0;
      negRem   <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      ready_o <= readyNext;
      if (loadOps) begin
        iterCnt  <= 6'd0;
        partRem  <= 32'd0;
        // A zero divisor reports the raw dividend, so skip the magnitude there.
        dividend <= divByZero ? opdata1_i : absDividend;
        divisor  <= absDivisor;
        negQuot  <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
        negRem   <= signed_div_i && opdata1_i[31];
      end
      if (doStep) begin
        iterCnt  <= iterCnt + 6'd1;
        dividend <= {dividend[30:0], fits};
        partRem  <= fits ? (trial[31:0] - divisor) : trial[31:0];
      end
      if (doFinish) begin
        result_o <= {remFinal, quotFinal};
      end
      if (doZero) begin
        result_o <= {dividend, 32'hFFFF_FFFF};
      end
    end
  end

endmodule
